// File: rtl/count_capture_unit.sv
// Input-capture stage: synchronises an async event line, timestamps the selected
// edge with the upstream count, and holds the result in a one-entry valid/ready register.
module count_capture_unit #(
  parameter int WIDTH       = 15,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] count_in,
  input  logic             event_in,
  input  logic [1:0]       edge_sel,
  input  logic             clear,
  input  logic             cap_ready,
  output logic             cap_valid,
  output logic [WIDTH-1:0] cap_value,
  output logic [WIDTH-1:0] cap_period,
  output logic             period_valid,
  output logic             overrun,
  output logic [7:0]       event_count
);

  localparam logic [0:0] EMPTY = 1'b0;
  localparam logic [0:0] FULL  = 1'b1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev;
  logic                   s;
  logic                   rise;
  logic                   fall;
  logic                   q;
  logic [0:0]             state;
  logic [WIDTH-1:0]       last_ref;
  logic                   seen;
  logic                   accept;

  // NOTE: every flop below uses non-blocking assignment so all registers
  // update from pre-edge values, regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q <= '0;
      prev   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
      prev   <= s;
    end
  end

  assign s    = sync_q[SYNC_STAGES-1];
  assign rise = s & ~prev;
  assign fall = ~s & prev;

  // NOTE: q gets a default before the case so no path leaves it unassigned,
  // which would otherwise infer a latch.
  always_comb begin
    q = 1'b0;
    case (edge_sel)
      2'b00:   q = rise;
      2'b01:   q = fall;
      2'b10:   q = rise | fall;
      default: q = 1'b0;
    endcase
  end

  // A new capture is accepted when the register is empty or is being popped this cycle.
  assign accept    = (state == EMPTY) || cap_ready;
  assign cap_valid = (state == FULL);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= EMPTY;
      cap_value    <= '0;
      cap_period   <= '0;
      period_valid <= 1'b0;
      overrun      <= 1'b0;
      event_count  <= '0;
      last_ref     <= '0;
      seen         <= 1'b0;
    end else if (clear) begin
      state       <= EMPTY;
      overrun     <= 1'b0;
      seen        <= 1'b0;
      event_count <= '0;
    end else if (q) begin
      last_ref <= count_in;
      seen     <= 1'b1;
      if (accept) begin
        state        <= FULL;
        cap_value    <= count_in;
        cap_period   <= count_in - last_ref;
        period_valid <= seen;
        if (event_count != 8'hFF) event_count <= event_count + 8'd1;
      end else begin
        overrun <= 1'b1;
      end
    end else if (state == FULL && cap_ready) begin
      state <= EMPTY;
    end
  end

endmodule

// File: tb/tb_count_capture_unit.sv
// Self-checking bench for count_capture_unit: a delay-line/queue level model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_count_capture_unit;

  localparam int W    = 15;
  localparam int SYNC = 2;
  localparam int MODV = 1 << W;

  logic         clk;
  logic         clk_en;
  logic         reset;
  logic [W-1:0] count_in;
  logic         event_in;
  logic [1:0]   edge_sel;
  logic         clear;
  logic         cap_ready;
  logic         cap_valid;
  logic [W-1:0] cap_value;
  logic [W-1:0] cap_period;
  logic         period_valid;
  logic         overrun;
  logic [7:0]   event_count;

  int errors = 0;
  int checks = 0;
  bit run    = 0;

  count_capture_unit #(.WIDTH(W), .SYNC_STAGES(SYNC)) dut (
    .clk          (clk),
    .reset        (reset),
    .count_in     (count_in),
    .event_in     (event_in),
    .edge_sel     (edge_sel),
    .clear        (clear),
    .cap_ready    (cap_ready),
    .cap_valid    (cap_valid),
    .cap_value    (cap_value),
    .cap_period   (cap_period),
    .period_valid (period_valid),
    .overrun      (overrun),
    .event_count  (event_count)
  );

  always begin
    #5;
    if (clk_en) clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: event levels sampled at each edge; a capture edge n qualifies when the
  // level sampled at edge n-SYNC differs from the one sampled at edge n-SYNC-1.
  logic   hist[$];
  bit     m_full;
  int     m_value, m_period, m_ref, m_cnt;
  bit     m_pv, m_ovr, m_seen;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      hist = {};
      for (int i = 0; i < SYNC + 1; i++) hist.push_back(1'b0);
      m_full = 0; m_value = 0; m_period = 0; m_ref = 0; m_cnt = 0;
      m_pv = 0; m_ovr = 0; m_seen = 0;
    end else begin
      bit cur, old, hit;
      int cnt;
      hist.push_back(event_in);
      while (hist.size() > SYNC + 2) void'(hist.pop_front());
      cur = hist[hist.size() - 1 - SYNC];
      old = hist[hist.size() - 2 - SYNC];
      case (edge_sel)
        2'd0:    hit = cur && !old;
        2'd1:    hit = !cur && old;
        2'd2:    hit = cur != old;
        default: hit = 0;
      endcase
      cnt = int'(count_in);
      if (clear) begin
        m_full = 0; m_ovr = 0; m_seen = 0; m_cnt = 0;
      end else if (hit) begin
        if (!m_full || cap_ready) begin
          m_full   = 1;
          m_value  = cnt;
          m_period = (cnt - m_ref + MODV) % MODV;
          m_pv     = m_seen;
          if (m_cnt < 255) m_cnt = m_cnt + 1;
        end else begin
          m_ovr = 1;
        end
        m_ref  = cnt;
        m_seen = 1;
      end else if (m_full && cap_ready) begin
        m_full = 0;
      end
    end
  end

  always @(negedge clk) begin
    if (run && reset) begin
      check("m_valid", 32'(cap_valid), 32'(m_full));
      check("m_overrun", 32'(overrun), 32'(m_ovr));
      check("m_count", 32'(event_count), 32'(m_cnt));
      if (m_full) begin
        check("m_value", 32'(cap_value), 32'(m_value));
        check("m_period", 32'(cap_period), 32'(m_period));
        check("m_pvalid", 32'(period_valid), 32'(m_pv));
      end
    end
  end

  task automatic drive(input logic [W-1:0] cnt, input logic ev, input logic rdy);
    count_in  = cnt;
    event_in  = ev;
    cap_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear(input logic ev, input logic rdy);
    clear = 1'b1;
    drive('0, ev, rdy);
    clear = 1'b0;
  endtask

  task automatic pulse(input logic [W-1:0] base, input logic rdy);
    for (int i = 0; i < 8; i++) drive(base + W'(i), (i < 4), rdy);
  endtask

  initial begin
    clk = 0; clk_en = 1; reset = 1;
    count_in = '0; event_in = 0; edge_sel = 2'b00; clear = 0; cap_ready = 0;
    #2 reset = 0;
    #1;
    check("rst_valid", 32'(cap_valid), 0);
    check("rst_count", 32'(event_count), 0);
    check("rst_overrun", 32'(overrun), 0);
    #9 reset = 1;
    @(posedge clk); #1;
    run = 1;

    // Rising edge basic
    drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 1, 0); drive(100, 1, 0);
    check("t1_valid", 32'(cap_valid), 1);
    check("t1_value", 32'(cap_value), 100);
    check("t1_pvalid", 32'(period_valid), 0);
    check("t1_count", 32'(event_count), 1);

    // Period with wrap
    do_clear(1, 1);
    check("clr_valid", 32'(cap_valid), 0);
    check("clr_count", 32'(event_count), 0);
    drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 1);
    drive(0, 1, 1); drive(0, 1, 1); drive(32760, 1, 1);
    check("t2a_value", 32'(cap_value), 32760);
    check("t2a_pvalid", 32'(period_valid), 0);
    drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 1);
    drive(0, 1, 1); drive(0, 1, 1); drive(5, 1, 1);
    check("t2_value", 32'(cap_value), 5);
    check("t2_period", 32'(cap_period), 13);
    check("t2_pvalid", 32'(period_valid), 1);

    // Overrun
    do_clear(1, 0);
    drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 1, 0); drive(10, 1, 0);
    drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 1, 0); drive(20, 1, 0);
    check("t3_value", 32'(cap_value), 10);
    check("t3_overrun", 32'(overrun), 1);
    check("t3_count", 32'(event_count), 1);
    drive(0, 0, 1);
    check("t3_pop", 32'(cap_valid), 0);
    drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 1, 0); drive(30, 1, 0);
    check("t3b_value", 32'(cap_value), 30);
    check("t3b_period", 32'(cap_period), 10);
    check("t3b_overrun", 32'(overrun), 1);

    // Pop with event in the same cycle
    do_clear(1, 0);
    drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 1, 0); drive(40, 1, 0);
    drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 1, 0); drive(50, 1, 1);
    check("t4_valid", 32'(cap_valid), 1);
    check("t4_value", 32'(cap_value), 50);
    check("t4_overrun", 32'(overrun), 0);
    check("t4_count", 32'(event_count), 2);

    // Edge select: both, falling, disabled
    do_clear(1, 1);
    drive(0, 0, 1); drive(0, 0, 1); drive(0, 0, 1);
    edge_sel = 2'b10;
    pulse(200, 1);
    check("t5b_count", 32'(event_count), 2);
    check("t5b_value", 32'(cap_value), 206);
    check("t5b_period", 32'(cap_period), 4);
    edge_sel = 2'b01;
    do_clear(0, 1);
    pulse(300, 1);
    check("t5f_count", 32'(event_count), 1);
    check("t5f_value", 32'(cap_value), 306);
    check("t5f_pvalid", 32'(period_valid), 0);
    edge_sel = 2'b11;
    do_clear(0, 1);
    pulse(400, 1);
    check("t5d_count", 32'(event_count), 0);
    check("t5d_valid", 32'(cap_valid), 0);

    // Clear coincident with q
    edge_sel = 2'b00;
    do_clear(0, 0);
    drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 1, 0);
    clear = 1'b1;
    drive(60, 1, 0);
    clear = 1'b0;
    check("t6_valid", 32'(cap_valid), 0);
    check("t6_count", 32'(event_count), 0);
    drive(0, 0, 0); drive(0, 0, 0); drive(0, 0, 0);
    drive(0, 1, 0); drive(0, 1, 0); drive(70, 1, 0);
    check("t6b_value", 32'(cap_value), 70);
    check("t6b_pvalid", 32'(period_valid), 0);
    check("t6b_count", 32'(event_count), 1);

    // Asynchronous reset with the clock stopped
    run = 0;
    clk_en = 0;
    #20 reset = 0;
    #1;
    check("ar_valid", 32'(cap_valid), 0);
    check("ar_value", 32'(cap_value), 0);
    check("ar_period", 32'(cap_period), 0);
    check("ar_pvalid", 32'(period_valid), 0);
    check("ar_overrun", 32'(overrun), 0);
    check("ar_count", 32'(event_count), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/count_capture_unit.md
Name: count_capture_unit

Overview:
- Input-capture stage directly downstream of the free-running up-counter; consumes its count bus.
- Synchronises an asynchronous event line and detects the selected edge.
- Timestamps each qualified event with the current count and computes the period since the previous event, modulo 2^WIDTH.
- Presents results through a single-entry valid/ready holding register, with sticky overrun reporting.

Parameters:
- WIDTH, 15: width of count_in, cap_value and cap_period.
- SYNC_STAGES, 2: flops in the event_in synchroniser chain (minimum 2).

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- count_in  input  WIDTH  count value from the upstream counter.
- event_in  input  1  asynchronous event line.
- edge_sel  input  2  qualifying edge: 00 rising, 01 falling, 10 both, 11 disabled.
- clear  input  1  synchronous clear of capture state.
- cap_ready  input  1  consumer accepts the current capture.
- cap_valid  output  1  holding register contains a capture.
- cap_value  output  WIDTH  count_in sampled at the qualifying edge.
- cap_period  output  WIDTH  cap_value minus previous event's count, modulo 2^WIDTH.
- period_valid  output  1  cap_period is meaningful (a previous event existed).
- overrun  output  1  sticky: an event was dropped because the register was full.
- event_count  output  8  saturating count of captures loaded.

Behaviour:
- Reset (reset=0): asynchronous, takes effect with no clock edge.
  - All outputs go to 0.
  - Synchroniser chain, prev-level flop, last_ref register and seen flag go to 0.
- Synchroniser: event_in passes through SYNC_STAGES flops; s = last stage.
- prev holds s delayed one cycle.
- Edge pulse, combinational from s and prev:
  - rise = s & ~prev; fall = ~s & prev.
  - Qualified pulse q selected by edge_sel; edge_sel=11 forces q=0.
- Latency: event_in changes with setup met before edge k; q is high during the cycle after edge k+SYNC_STAGES-1; capture occurs at edge k+SYNC_STAGES and samples count_in at that edge.
- Startup: event_in high when reset is released yields a rising edge after SYNC_STAGES edges. This is required behaviour.
- Holding register FSM, states EMPTY (cap_valid=0) and FULL (cap_valid=1). Priority at each edge: clear, then q, then pop.
  - clear=1: go to EMPTY; overrun, seen and event_count go to 0; last_ref holds. A q in the same cycle is discarded entirely (no load, no ref update). Synchroniser and prev are unaffected.
  - EMPTY and q: load the capture; go to FULL.
  - FULL, q and cap_ready=1 (pop and event together): load the new capture; stay FULL; no overrun.
  - FULL, q and cap_ready=0: keep the held data; set overrun=1.
  - FULL, no q, cap_ready=1: go to EMPTY; data outputs hold their last values.
- Load action:
  - cap_value <= count_in.
  - cap_period <= count_in - last_ref, truncated to WIDTH bits.
  - period_valid <= seen.
  - event_count <= event_count+1, saturating at 255.
- On every q that is not cleared, including dropped events: last_ref <= count_in; seen <= 1.
- overrun clears only on reset or clear.
- cap_ready while EMPTY is ignored.
- Outputs are stable while cap_valid=1 and cap_ready=0.

Test Plan:
- Rising edge basic. Stimulus: edge_sel=00, cap_ready=0, event_in rises before edge k, count_in=100 at edge k+2. Required: cap_valid=1 after edge k+2, cap_value=100, period_valid=0, event_count=1.
- Period with wrap. Stimulus: WIDTH=15, cap_ready=1, events captured at count_in=32760 then 5. Required: second capture has cap_period=13 and period_valid=1.
- Overrun. Stimulus: cap_ready=0, edges captured at 10 and 20. Required: cap_value stays 10, overrun=1, event_count=1. Then pop, edge at 30 → cap_value=30, cap_period=10, overrun remains 1.
- Pop with event in the same cycle. Stimulus: FULL with value 40, cap_ready=1 in the cycle q fires with count_in=50. Required: cap_valid stays 1, cap_value=50, overrun=0.
- Edge select. Stimulus: edge_sel=10, 4-cycle-wide high pulse. Required: two captures, second has cap_period=4. Repeat with edge_sel=01 → one capture on the fall; edge_sel=11 → no captures.
- Clear and reset. Stimulus: clear=1 coincident with q. Required: no load, cap_valid=0, event_count=0, next capture has period_valid=0. Then drive reset low mid-FULL with clk stopped. Required: all outputs 0 immediately.
